// File: rtl/mlp_pkg.sv
// Shared constants, trained weights and FSM state type for the sequential 6-3-3 MLP scheduler.
package mlp_pkg;
    localparam int N_IN   = 6;
    localparam int IN_W   = 5;
    localparam int N_HID  = 3;
    localparam int N_OUT  = 3;
    localparam int W_W    = 8;
    localparam int ACC0_W = 13;
    localparam int ACC1_W = 20;
    localparam int CLS_W  = 2;
    localparam int H_W    = ACC0_W - 1;
    localparam int Y_W    = ACC1_W - 1;
    localparam int TERM_W = 3;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L0   = 2'd1,
        S_L1   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [W_W-1:0] W0 [N_HID][N_IN] = '{
        '{ 8'sd20, -8'sd30,  8'sd0,  8'sd32,  8'sd40,   8'sd8},
        '{-8'sd4,  -8'sd8,   8'sd0, -8'sd4,  -8'sd4,    8'sd0},
        '{ 8'sd0,   8'sd8,   8'sd8, -8'sd16, -8'sd16,   8'sd108}
    };

    // Biases are stored at the shared MAC width; layer-0 values fit ACC0_W unchanged.
    localparam logic signed [ACC1_W-1:0] B0 [N_HID] = '{20'sd28, -20'sd69, 20'sd83};

    localparam logic signed [W_W-1:0] W1 [N_OUT][N_HID] = '{
        '{-8'sd20, 8'sd4, -8'sd36},
        '{ 8'sd20, 8'sd0,  8'sd52},
        '{ 8'sd8,  8'sd0, -8'sd16}
    };

    localparam logic signed [ACC1_W-1:0] B1 [N_OUT] = '{20'sd18608, -20'sd19355, 20'sd1983};
endpackage

// File: rtl/mlp_mac.sv
// Shared signed multiply-accumulate: unsigned operand times signed weight, added to the
// running accumulator or, on load, to a bias. The sum is exposed combinationally.
module mlp_mac #(
    parameter int A_W   = 12,
    parameter int W_W   = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [A_W-1:0]   a,
    input  logic [W_W-1:0]   w,
    input  logic [ACC_W-1:0] bias,
    output logic [ACC_W-1:0] sum
);
    logic signed [A_W+W_W:0] prod;
    logic [ACC_W-1:0]        acc_q;

    assign prod = $signed({1'b0, a}) * $signed(w);
    assign sum  = (load ? bias : acc_q) + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end
endmodule

// File: rtl/mlp_seq_sched.sv
// Time-multiplexed 6-3-3 MLP: one MAC steps every layer-0 then layer-1 term on a fixed
// schedule, tracks a running argmax and holds the result until the consumer takes it.
module mlp_seq_sched
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLS_W-1:0]       out_cls,
    output logic [N_OUT*Y_W-1:0]   predo,
    output logic                   busy,
    output logic [1:0]             dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_valid is ignored unless idle, and out_valid holds its data until out_ready is seen.
    state_t                state_q, state_d;
    logic [N_IN*IN_W-1:0]  x_q;
    logic [IN_W-1:0]       x_f [N_IN];
    logic [IDX_W-1:0]      idx_q;
    logic [TERM_W-1:0]     term_q;
    logic [H_W-1:0]        h_q [N_HID];
    logic [N_OUT*Y_W-1:0]  predo_q;
    logic [Y_W-1:0]        best_q;
    logic [CLS_W-1:0]      cls_q;

    logic                  mac_en, mac_load;
    logic [H_W-1:0]        mac_a;
    logic [W_W-1:0]        mac_w;
    logic [ACC1_W-1:0]     mac_b, mac_sum;
    logic [H_W-1:0]        relu0;
    logic [Y_W-1:0]        relu1;
    logic                  last_t0, last_t1, last_hid, last_out;

    always_comb begin
        for (int f = 0; f < N_IN; f++) begin
            x_f[f] = x_q[f*IN_W +: IN_W];
        end
    end

    assign last_t0  = (term_q == TERM_W'(N_IN - 1));
    assign last_t1  = (term_q == TERM_W'(N_HID - 1));
    assign last_hid = (idx_q == IDX_W'(N_HID - 1));
    assign last_out = (idx_q == IDX_W'(N_OUT - 1));

    always_comb begin
        mac_a = H_W'(x_f[term_q]);
        mac_w = W0[idx_q][term_q];
        mac_b = B0[idx_q];
        if (state_q == S_L1) begin
            mac_a = h_q[term_q[1:0]];
            mac_w = W1[idx_q][term_q[1:0]];
            mac_b = B1[idx_q];
        end
    end

    assign mac_en   = (state_q == S_L0) || (state_q == S_L1);
    assign mac_load = (term_q == '0);

    mlp_mac #(.A_W(H_W), .W_W(W_W), .ACC_W(ACC1_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .load  (mac_load),
        .a     (mac_a),
        .w     (mac_w),
        .bias  (mac_b),
        .sum   (mac_sum)
    );

    // Low ACC0_W bits of the wide sum equal a true ACC0_W-bit wrapping accumulation.
    assign relu0 = mac_sum[ACC0_W-1] ? '0 : mac_sum[ACC0_W-2:0];
    assign relu1 = mac_sum[ACC1_W-1] ? '0 : mac_sum[ACC1_W-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_L0;
            end
            S_L0:   if (last_t0 && last_hid) state_d = S_L1;
            S_L1:   if (last_t1 && last_out) state_d = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            idx_q   <= '0;
            term_q  <= '0;
            predo_q <= '0;
            best_q  <= '0;
            cls_q   <= '0;
            for (int j = 0; j < N_HID; j++) h_q[j] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    x_q    <= in_data;
                    idx_q  <= '0;
                    term_q <= '0;
                end
                S_L0: if (last_t0) begin
                    h_q[idx_q] <= relu0;
                    term_q     <= '0;
                    idx_q      <= last_hid ? '0 : idx_q + 1'b1;
                end else begin
                    term_q <= term_q + 1'b1;
                end
                S_L1: if (last_t1) begin
                    for (int o = 0; o < N_OUT; o++) begin
                        if (32'(idx_q) == o) predo_q[(N_OUT-1-o)*Y_W +: Y_W] <= relu1;
                    end
                    // Strict compare keeps the lower index on ties.
                    if (idx_q == '0 || relu1 > best_q) begin
                        best_q <= relu1;
                        cls_q  <= idx_q;
                    end
                    term_q <= '0;
                    idx_q  <= last_out ? '0 : idx_q + 1'b1;
                end else begin
                    term_q <= term_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_cls   = cls_q;
    assign predo     = predo_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mlp_seq_sched.sv
// Directed bench for mlp_seq_sched: integer reference model, cycle-level compare process
// and hand-computed literal results for the reference vectors.
module tb_mlp_seq_sched;
    import mlp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_cls;
    logic [56:0] predo;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b1;

    // Reference model state: cycles since accept and queued expected {cls, predo}.
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;
    int  m_cnt  = 0;
    logic [58:0] exp_q[$];

    int w0_t [3][6] = '{'{20, -30, 0, 32, 40, 8}, '{-4, -8, 0, -4, -4, 0}, '{0, 8, 8, -16, -16, 108}};
    int b0_t [3]    = '{28, -69, 83};
    int w1_t [3][3] = '{'{-20, 4, -36}, '{20, 0, 52}, '{8, 0, -16}};
    int b1_t [3]    = '{18608, -19355, 1983};

    localparam logic [56:0] P_ZERO = {19'd15060, 19'd0, 19'd879};
    localparam logic [56:0] P_ONES = {19'd0, 19'd177225, 19'd0};
    localparam logic [56:0] P_F3   = {19'd0, 19'd1045, 19'd10143};

    mlp_seq_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cls   (out_cls),
        .predo     (predo),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap(input int v, input int n);
        int m;
        m = v & ((1 << n) - 1);
        if (m >= (1 << (n - 1))) m = m - (1 << n);
        return m;
    endfunction

    function automatic void model(input logic [29:0] d, output logic [56:0] p, output logic [1:0] c);
        int h [3];
        int s, y, best;
        p = '0;
        c = '0;
        best = 0;
        for (int j = 0; j < 3; j++) begin
            s = b0_t[j];
            for (int f = 0; f < 6; f++) s += int'(d[f*5 +: 5]) * w0_t[j][f];
            s = wrap(s, 13);
            h[j] = (s < 0) ? 0 : s;
        end
        for (int o = 0; o < 3; o++) begin
            s = b1_t[o];
            for (int j = 0; j < 3; j++) s += h[j] * w1_t[o][j];
            s = wrap(s, 20);
            y = (s < 0) ? 0 : s;
            p[(2 - o)*19 +: 19] = 19'(y);
            if (o == 0 || y > best) begin
                best = y;
                c = 2'(o);
            end
        end
    endfunction

    // ---------------- reference model ----------------
    always @(posedge clk or negedge rst_n) begin
        logic [56:0] p;
        logic [1:0]  c;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                model(in_data, p, c);
                exp_q.push_back({c, p});
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (!m_done) begin
            m_cnt++;
            if (m_cnt == 27) m_done = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            void'(exp_q.pop_front());
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        state_t exp_st;
        if (chk_en) begin
            exp_st = !m_busy ? S_IDLE : m_done ? S_DONE : (m_cnt < 18) ? S_L0 : S_L1;
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_done));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("state", 64'(dbg_state), 64'(exp_st));
            if (m_done && exp_q.size() > 0) begin
                chk("predo", 64'(predo), 64'(exp_q[0][56:0]));
                chk("out_cls", 64'(out_cls), 64'(exp_q[0][58:57]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [29:0] d);
        bit ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_result(input string name, input logic [56:0] exp_p, input logic [1:0] exp_c);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({name, "_latency"}, 64'(cyc - acc_cyc), 64'd27);
            chk({name, "_predo"}, 64'(predo), 64'(exp_p));
            chk({name, "_cls"}, 64'(out_cls), 64'(exp_c));
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [56:0] p;
        logic [1:0]  c;
        bit          rose;

        // Pin the model to the hand-computed reference results.
        model(30'h0, p, c);
        chk("pin_zero_p", 64'(p), 64'(P_ZERO));
        chk("pin_zero_c", 64'(c), 64'd0);
        model(30'h3FFFFFFF, p, c);
        chk("pin_ones_p", 64'(p), 64'(P_ONES));
        chk("pin_ones_c", 64'(c), 64'd1);
        model(30'h000F8000, p, c);
        chk("pin_f3_p", 64'(p), 64'(P_F3));
        chk("pin_f3_c", 64'(c), 64'd2);

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_predo", 64'(predo), 64'd0);
        chk("rst_cls", 64'(out_cls), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Reference vectors.
        send(30'h0);
        wait_result("zero", P_ZERO, 2'd0);
        send(30'h3FFFFFFF);
        wait_result("ones", P_ONES, 2'd1);
        send(30'h000F8000);
        wait_result("f3", P_F3, 2'd2);
        @(posedge clk);
        #2;

        // Consumer stall: result must hold for 10 cycles, then the next sample starts.
        out_ready = 1'b0;
        send(30'h0);
        wait_result("stall", P_ZERO, 2'd0);
        repeat (10) @(negedge clk);
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_ready", 64'(in_ready), 64'd0);
        chk("stall_hold_predo", 64'(predo), 64'(P_ZERO));
        #2;
        out_ready = 1'b1;
        send(30'h3FFFFFFF);
        wait_result("after_stall", P_ONES, 2'd1);
        @(posedge clk);
        #2;

        // in_valid pulses while busy must be ignored.
        send(30'h000F8000);
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_data  = 30'h3FFFFFFF;
        repeat (2) @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_data  = 30'h0;
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_result("busy_ignore", P_F3, 2'd2);
        @(posedge clk);
        #2;

        // Reset in the middle of layer 0 aborts the sample.
        send(30'h3FFFFFFF);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_predo", 64'(predo), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        chk("abort_no_result", 64'(rose), 64'd0);
        chk("abort_idle_ready", 64'(in_ready), 64'd1);
        #2;
        send(30'h0);
        wait_result("post_abort", P_ZERO, 2'd0);
        repeat (3) @(posedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
